// File: rtl/core2_sched_pkg.sv
// Shared types and default widths for the Core2 job scheduler.
package core2_sched_pkg;

  localparam int DEF_OP_W  = 128;
  localparam int DEF_RES_W = 256;
  localparam int DEF_CMD_W = 4;

  // Requester identity, also the payload of the tag FIFO
  typedef logic [0:0] req_id_t;

  // Response-path state: poll output FIFO, capture, hold for requester
  typedef enum logic [1:0] {R_IDLE, R_READ, R_HOLD} rsp_state_t;

endpackage

// File: rtl/core2_job_scheduler_if.sv
// Requester and Core2 FIFO signals of the job scheduler.
// master: the scheduler side; slave: requesters + Core2 FIFOs.
interface core2_job_scheduler_if #(
  parameter int OP_W  = core2_sched_pkg::DEF_OP_W,
  parameter int RES_W = core2_sched_pkg::DEF_RES_W,
  parameter int CMD_W = core2_sched_pkg::DEF_CMD_W
);
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [OP_W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [CMD_W-1:0] req0_cmd, req1_cmd;
  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready, rsp1_ready;
  logic [RES_W-1:0] rsp_data;
  logic             wr_en_inp;
  logic [OP_W-1:0]  data_a, data_b;
  logic             in_busy_inp;
  logic             wr_en_cmd;
  logic [CMD_W-1:0] data_cmd;
  logic             in_busy_cmd;
  logic             rd_en_out;
  logic [RES_W-1:0] data_out;
  logic             out_busy_out;
  logic             err_orphan;

  modport master (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_cmd, req1_cmd,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data,
    input  rsp0_ready, rsp1_ready,
    output wr_en_inp, data_a, data_b, wr_en_cmd, data_cmd,
    input  in_busy_inp, in_busy_cmd,
    output rd_en_out,
    input  data_out, out_busy_out,
    output err_orphan
  );

  modport slave (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_cmd, req1_cmd,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data,
    output rsp0_ready, rsp1_ready,
    input  wr_en_inp, data_a, data_b, wr_en_cmd, data_cmd,
    output in_busy_inp, in_busy_cmd,
    input  rd_en_out,
    output data_out, out_busy_out,
    input  err_orphan
  );
endinterface

// File: rtl/core2_tag_fifo.sv
// Requester-ID FIFO: one entry per job issued to Core2, popped in result order.
module core2_tag_fifo
  import core2_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  req_id_t din,
  output req_id_t dout,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);

  req_id_t       mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  // Storage: no reset needed, validity tracked by cnt
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/core2_job_scheduler.sv
// Two-requester round-robin scheduler in front of Core2's input/command/output FIFOs.
// Results are returned in issue order, routed by a per-job requester tag.
// Optional: define CORE2_SCHED_STATS_EN to add stat_issued / stat_done counters.
module core2_job_scheduler
  import core2_sched_pkg::*;
#(
  parameter int OP_W    = DEF_OP_W,
  parameter int RES_W   = DEF_RES_W,
  parameter int CMD_W   = DEF_CMD_W,
  parameter int MAX_OUT = 8
) (
  input  logic clk,
  input  logic rst,
  core2_job_scheduler_if.master bus
`ifdef CORE2_SCHED_STATS_EN
  ,
  output logic [31:0] stat_issued,
  output logic [31:0] stat_done
`endif
);
  localparam int CW = $clog2(MAX_OUT) + 1;

  req_id_t          last_grant, tag_dout, rsp_tag;
  logic             tag_full, tag_empty, tag_pop;
  logic [CW-1:0]    outstanding;
  logic             can_issue, gnt0, gnt1, grant, handoff;
  logic [OP_W-1:0]  a_mux, b_mux;
  logic [CMD_W-1:0] c_mux;
  logic             rd_en, v0, v1;
  logic [RES_W-1:0] rsp_q;
  logic             err_q;
  rsp_state_t       state, state_nxt;

  // Issue side: both Core2 FIFOs must have room and the job budget must allow it
  assign can_issue = !bus.in_busy_inp && !bus.in_busy_cmd && !tag_full &&
                     (outstanding < CW'(MAX_OUT));
  assign gnt0  = can_issue && bus.req0_valid && (!bus.req1_valid || last_grant == 1'b1);
  assign gnt1  = can_issue && bus.req1_valid && (!bus.req0_valid || last_grant == 1'b0);
  assign grant = gnt0 || gnt1;

  // Winner's job onto the Core2 write buses; zero when idle
  always_comb begin
    a_mux = '0;
    b_mux = '0;
    c_mux = '0;
    if (gnt0) begin
      a_mux = bus.req0_a;
      b_mux = bus.req0_b;
      c_mux = bus.req0_cmd;
    end else if (gnt1) begin
      a_mux = bus.req1_a;
      b_mux = bus.req1_b;
      c_mux = bus.req1_cmd;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.wr_en_inp  = grant;
  assign bus.wr_en_cmd  = grant;
  assign bus.data_a     = a_mux;
  assign bus.data_b     = b_mux;
  assign bus.data_cmd   = c_mux;

  // Round-robin pointer; reset to 1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst)        last_grant <= 1'b1;
    else if (grant) last_grant <= req_id_t'(gnt1);
  end

  // Jobs in flight: a same-cycle grant and handoff cancel
  always_ff @(posedge clk) begin
    if (rst) outstanding <= '0;
    else begin
      case ({grant, handoff})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  core2_tag_fifo #(.DEPTH(MAX_OUT)) u_tag (
    .clk   (clk),
    .rst   (rst),
    .push  (grant),
    .pop   (tag_pop),
    .din   (req_id_t'(gnt1)),
    .dout  (tag_dout),
    .full  (tag_full),
    .empty (tag_empty)
  );

  // Response FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= R_IDLE;
    else     state <= state_nxt;
  end

  // Response FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      R_IDLE:  if (!bus.out_busy_out) state_nxt = R_READ;
      R_READ:  state_nxt = tag_empty ? R_IDLE : R_HOLD;
      R_HOLD:  if (handoff) state_nxt = R_IDLE;
      default: state_nxt = R_IDLE;
    endcase
  end

  // Response FSM outputs: only the tagged requester ever sees valid
  always_comb begin
    rd_en   = 1'b0;
    tag_pop = 1'b0;
    v0      = 1'b0;
    v1      = 1'b0;
    handoff = 1'b0;
    case (state)
      R_IDLE: rd_en   = !bus.out_busy_out;
      R_READ: tag_pop = 1'b1;
      R_HOLD: begin
        v0      = (rsp_tag == 1'b0);
        v1      = (rsp_tag == 1'b1);
        handoff = rsp_tag[0] ? bus.rsp1_ready : bus.rsp0_ready;
      end
      default: ;
    endcase
  end

  // Result capture; a result with no tag is dropped and flagged until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_q   <= '0;
      rsp_tag <= '0;
      err_q   <= 1'b0;
    end else if (state == R_READ) begin
      if (tag_empty) begin
        err_q <= 1'b1;
      end else begin
        rsp_q   <= bus.data_out;
        rsp_tag <= tag_dout;
      end
    end
  end

  assign bus.rd_en_out  = rd_en;
  assign bus.rsp0_valid = v0;
  assign bus.rsp1_valid = v1;
  assign bus.rsp_data   = rsp_q;
  assign bus.err_orphan = err_q;

`ifdef CORE2_SCHED_STATS_EN
  // Wrapping grant / handoff counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued <= '0;
      stat_done   <= '0;
    end else begin
      if (grant)   stat_issued <= stat_issued + 32'd1;
      if (handoff) stat_done   <= stat_done + 32'd1;
    end
  end
`endif
endmodule

// File: doc/core2_job_scheduler.md
# core2_job_scheduler

Two-requester scheduler in front of the Core2 FIFO interface. Round-robin arbitrates operand/command jobs from two masters into Core2's input and command FIFOs. Records each issued job's requester ID in an internal tag FIFO. Drains Core2's output FIFO in order, routing each 256-bit result back to the requester that issued it, and blocks issue once the outstanding-job limit is reached.

## Interface
Parameters:
- OP_W, 128, operand width (A and B each)
- RES_W, 256, result width
- CMD_W, 4, command width (Core2 decodes [2:0])
- MAX_OUT, 8, max outstanding jobs; power of two, 2..64

Ports:
- clk, in, 1, sole clock
- rst, in, 1, synchronous, active-high reset
- req0_valid / req1_valid, in, 1, job offered
- req0_ready / req1_ready, out, 1, job accepted this cycle
- req0_a, req0_b / req1_a, req1_b, in, OP_W, operands
- req0_cmd / req1_cmd, in, CMD_W, Core2 command
- rsp0_valid / rsp1_valid, out, 1, result held for requester
- rsp0_ready / rsp1_ready, in, 1, requester takes result
- rsp_data, out, RES_W, shared result bus
- wr_en_inp, out, 1, Core2 input FIFO write
- data_a, data_b, out, OP_W, to input FIFO
- in_busy_inp, in, 1, input FIFO full
- wr_en_cmd, out, 1, Core2 command FIFO write
- data_cmd, out, CMD_W, to command FIFO
- in_busy_cmd, in, 1, command FIFO full
- rd_en_out, out, 1, Core2 output FIFO read
- data_out, in, RES_W, output FIFO data, valid one cycle after rd_en_out
- out_busy_out, in, 1, output FIFO empty
- err_orphan, out, 1, sticky: result arrived with no tag

## Operation
- Issue is combinational in the grant cycle: can_issue = !in_busy_inp && !in_busy_cmd && !tag_full && outstanding < MAX_OUT.
- Grant goes to the valid requester; if both are valid, it goes to the one not granted last.
- A 1-bit registered last_grant pointer updates only on an actual grant.
- On a grant: reqN_ready=1, wr_en_inp=wr_en_cmd=1, data_a/b/cmd muxed from the winner, and the winner ID is pushed to the tag FIFO.
- Input and command FIFO writes are always paired; never one without the other.
- Response FSM:
  - R_IDLE: if !out_busy_out, assert rd_en_out for 1 cycle and go to R_READ.
  - R_READ: capture data_out into rsp_data and pop the tag.
    - Tag present: go to R_HOLD.
    - Tag FIFO empty: set err_orphan, discard the result, return to R_IDLE.
  - R_HOLD: rsp{tag}_valid=1, rsp_data stable. When rsp{tag}_ready=1, go to R_IDLE and decrement outstanding.
- The other requester's rsp_valid stays 0 (in-order, head-of-line blocking).
- outstanding counter:
  - +1 on grant; −1 on R_HOLD handoff.
  - Simultaneous grant and handoff: unchanged.
  - Width clog2(MAX_OUT)+1; never wraps.

## Timing
- Reset values:
  - All outputs 0; rsp_data 0; err_orphan 0.
  - FSM in R_IDLE; outstanding 0; tag FIFO empty; last_grant=1, so requester 0 wins the first tie.
- Issue latency 0: a job is written to the Core2 FIFOs in the cycle its ready is high.
- Result path: rd_en_out at cycle t, capture at t+1, rsp_valid from t+2. Minimum 3 cycles per result.
- Issue and response paths run concurrently; a grant and a handoff may occur in the same cycle.
- Full FIFOs: if either in_busy is high, both readies are 0 and no writes occur.
- tag_full or outstanding==MAX_OUT: no grant.
- rsp_ready low: hold indefinitely. Only the FSM reads the output FIFO, so it fills and Core2 back-pressures.
- Reset mid-operation: tags and counter are cleared, but jobs already inside Core2 survive. Their results therefore arrive orphaned, are drained and discarded, and set err_orphan. err_orphan clears only on rst.

## Configuration
- CORE2_SCHED_STATS_EN defined: adds ports stat_issued (out, 32) and stat_done (out, 32).
  - stat_issued counts grants; stat_done counts handoffs.
  - Both are wrapping, reset to 0.
- Not defined: those ports and counters are absent; all other behaviour is identical.

## Structure
- Package core2_sched_pkg holds:
  - OP_W, RES_W and CMD_W defaults
  - req_id_t (1 bit)
  - response FSM state enum {R_IDLE, R_READ, R_HOLD}
- Sub-module core2_tag_fifo: synchronous FIFO, depth MAX_OUT, width 1, ports push/pop/full/empty/dout, cleared on rst.

## Test plan
- Single job: req0 with a=1, b=2, cmd=3; output FIFO returns 0xABCD two cycles later. Required: wr_en_inp/wr_en_cmd pulse once with data_a=1, data_b=2, data_cmd=3; rsp0_valid with rsp_data=0xABCD; rsp1_valid stays 0.
- Both requesters valid for 4 cycles: grants alternate 0,1,0,1. Results return in order and are routed by tag to rsp0, rsp1, rsp0, rsp1.
- in_busy_inp held high for 5 cycles with req0_valid=1: no ready and no writes. The job issues in the first cycle busy drops.
- 9 jobs with responses withheld, MAX_OUT=8: exactly 8 issue; the 9th issues one cycle after the first handoff.
- rsp1_ready low for 10 cycles with a result held: rsp_data stays stable and rd_en_out stays 0 until the handoff.
- rst after 3 issued jobs, then Core2 emits 3 results: all 3 are discarded, err_orphan=1, and no rsp_valid is asserted.
